display_mode_sequencer: RTL and testbench

- Master controller for the display path. Generates the 2-bit MASTER_CONTROL word consumed by the VGA colour generator, which outputs its pattern only when MASTER_CONTROL = 2'b10.
- Sequences IDLE -> RUN (timer display) -> PATTERN (animated colour pattern) -> DONE, driven by start/stop pulses, a seconds timer and a frame counter.
- Sits between the button front end and the VGA colour/timer display blocks.

---
 rtl/display_pkg.sv | 20 ++
 rtl/tick_prescaler.sv | 30 +++
 rtl/display_mode_sequencer.sv | 127 ++++++++++++
 tb/tb_display_mode_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared display-path constants.
//   MODE_* : MASTER_CONTROL encodings (state register doubles as the output word)
//   FRAME_END_Y : scan line on which the frame tick is raised by the VGA blocks
package display_pkg;

    localparam logic [1:0] MODE_IDLE    = 2'b00;
    localparam logic [1:0] MODE_RUN     = 2'b01;
    localparam logic [1:0] MODE_PATTERN = 2'b10;
    localparam logic [1:0] MODE_DONE    = 2'b11;

    localparam int FRAME_END_Y = 480;

    typedef enum logic [1:0] {
        ST_IDLE    = MODE_IDLE,
        ST_RUN     = MODE_RUN,
        ST_PATTERN = MODE_PATTERN,
        ST_DONE    = MODE_DONE
    } mode_e;

endpackage

// File: rtl/tick_prescaler.sv
// One-second tick generator.
//   CLK, RESET (sync, active-low)
//   clear  : forces the count to 0 (wins over enable)
//   enable : advance the count this cycle
//   tick   : high on the cycle the count sits at CLK_PER_SEC-1 while enabled
module tick_prescaler #(
    parameter int CLK_PER_SEC = 100_000_000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int W = $clog2(CLK_PER_SEC);
    localparam logic [W-1:0] TC = W'(CLK_PER_SEC - 1);

    logic [W-1:0] cnt;

    assign tick = enable & ~clear & (cnt == TC);

    always_ff @(posedge CLK) begin
        if (!RESET || clear)
            cnt <= '0;
        else if (enable)
            cnt <= (cnt == TC) ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/display_mode_sequencer.sv
// Display-path master controller: IDLE -> RUN -> PATTERN -> DONE.
//   CLK, RESET (sync, active-low)
//   START_PULSE, STOP_PULSE : single-cycle requests (STOP has priority)
//   FRAME_TICK              : level, high during the frame-end line
//   MASTER_CONTROL          : current mode word (00 idle, 01 run, 10 pattern, 11 done)
//   SECONDS                 : whole seconds elapsed in RUN
//   MODE_CHANGE             : one-cycle pulse after every state transition
module display_mode_sequencer
    import display_pkg::*;
#(
    parameter int CLK_PER_SEC    = 100_000_000,
    parameter int RUN_SECONDS    = 10,
    parameter int PATTERN_FRAMES = 600
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START_PULSE,
    input  logic       STOP_PULSE,
    input  logic       FRAME_TICK,
    output logic [1:0] MASTER_CONTROL,
    output logic [7:0] SECONDS,
    output logic       MODE_CHANGE
);

    localparam logic [7:0]  SEC_LAST = 8'(RUN_SECONDS - 1);
    localparam logic [15:0] FRM_LAST = 16'(PATTERN_FRAMES - 1);

    mode_e       state, state_nx;
    logic [7:0]  seconds;
    logic [15:0] frm_cnt;
    logic        frame_d;
    logic        frame_edge;
    logic        sec_tick;
    logic        sec_clr, sec_inc, frm_clr, frm_inc;
    logic        psc_clr;

    // One count per frame regardless of how long the tick level is held.
    assign frame_edge = FRAME_TICK & ~frame_d;

    // Prescaler only runs in RUN; any start/stop restarts it, so it is
    // always at 0 on entry to RUN.
    assign psc_clr = (state != ST_RUN) | START_PULSE | STOP_PULSE;

    tick_prescaler #(.CLK_PER_SEC(CLK_PER_SEC)) u_psc (
        .CLK    (CLK),
        .RESET  (RESET),
        .clear  (psc_clr),
        .enable (state == ST_RUN),
        .tick   (sec_tick)
    );

    always_comb begin
        state_nx = state;
        sec_clr  = 1'b0;
        sec_inc  = 1'b0;
        frm_clr  = 1'b0;
        frm_inc  = 1'b0;
        case (state)
            ST_IDLE: begin
                sec_clr = 1'b1;
                frm_clr = 1'b1;
                if (!STOP_PULSE && START_PULSE)
                    state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (STOP_PULSE) begin
                    state_nx = ST_IDLE;
                    sec_clr  = 1'b1;
                    frm_clr  = 1'b1;
                end else if (START_PULSE) begin
                    sec_clr = 1'b1;  // restart in place, no transition
                end else if (sec_tick) begin
                    sec_inc = 1'b1;
                    if (seconds == SEC_LAST) begin
                        state_nx = ST_PATTERN;
                        frm_clr  = 1'b1;
                    end
                end
            end
            ST_PATTERN: begin
                if (STOP_PULSE) begin
                    state_nx = ST_IDLE;
                    sec_clr  = 1'b1;
                    frm_clr  = 1'b1;
                end else if (frame_edge) begin
                    frm_inc = 1'b1;
                    if (frm_cnt == FRM_LAST)
                        state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                if (STOP_PULSE || START_PULSE) begin
                    state_nx = STOP_PULSE ? ST_IDLE : ST_RUN;
                    sec_clr  = 1'b1;
                    frm_clr  = 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                sec_clr  = 1'b1;
                frm_clr  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state       <= ST_IDLE;
            seconds     <= '0;
            frm_cnt     <= '0;
            frame_d     <= 1'b0;
            MODE_CHANGE <= 1'b0;
        end else begin
            state       <= state_nx;
            frame_d     <= FRAME_TICK;
            MODE_CHANGE <= (state_nx != state);
            if (sec_clr)      seconds <= '0;
            else if (sec_inc) seconds <= seconds + 8'd1;
            if (frm_clr)      frm_cnt <= '0;
            else if (frm_inc) frm_cnt <= frm_cnt + 16'd1;
        end
    end

    assign MASTER_CONTROL = state;
    assign SECONDS        = seconds;

endmodule

// File: tb/tb_display_mode_sequencer.sv
module tb_display_mode_sequencer;

    localparam int CPS = 4;
    localparam int RS  = 3;
    localparam int PF  = 2;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       START_PULSE = 1'b0;
    logic       STOP_PULSE = 1'b0;
    logic       FRAME_TICK = 1'b0;
    logic [1:0] MASTER_CONTROL;
    logic [7:0] SECONDS;
    logic       MODE_CHANGE;

    int vectors = 0;
    int errors  = 0;

    display_mode_sequencer #(
        .CLK_PER_SEC(CPS), .RUN_SECONDS(RS), .PATTERN_FRAMES(PF)
    ) dut (
        .CLK(CLK), .RESET(RESET), .START_PULSE(START_PULSE), .STOP_PULSE(STOP_PULSE),
        .FRAME_TICK(FRAME_TICK), .MASTER_CONTROL(MASTER_CONTROL), .SECONDS(SECONDS),
        .MODE_CHANGE(MODE_CHANGE)
    );

    always #5 CLK = ~CLK;

    // Behavioural model: mode plus "cycles spent in RUN" and "frames seen in
    // PATTERN"; seconds derived by division.
    int m_mode = 0, m_sec = 0, m_run_cyc = 0, m_frames = 0, m_mc = 0;
    bit m_prev_tick = 0, started = 0;

    always @(posedge CLK) begin
        int  old_mode;
        bit  fe;
        started  = 1;
        old_mode = m_mode;
        if (!RESET) begin
            m_mode = 0; m_sec = 0; m_run_cyc = 0; m_frames = 0; m_prev_tick = 0; m_mc = 0;
        end else begin
            fe = FRAME_TICK && !m_prev_tick;
            m_prev_tick = FRAME_TICK;
            if (STOP_PULSE) begin
                if (m_mode != 0) begin m_mode = 0; m_sec = 0; m_run_cyc = 0; m_frames = 0; end
            end else if (START_PULSE && m_mode != 2) begin
                m_mode = 1; m_sec = 0; m_run_cyc = 0; m_frames = 0;
            end else if (m_mode == 1) begin
                m_run_cyc++;
                m_sec = m_run_cyc / CPS;
                if (m_run_cyc == RS * CPS) begin m_mode = 2; m_frames = 0; end
            end else if (m_mode == 2 && fe) begin
                m_frames++;
                if (m_frames == PF) m_mode = 3;
            end
            m_mc = (m_mode != old_mode);
        end
    end

    always @(negedge CLK) begin
        if (started) begin
            vectors++;
            if (MASTER_CONTROL !== 2'(m_mode) || SECONDS !== 8'(m_sec) || MODE_CHANGE !== 1'(m_mc)) begin
                errors++;
                $display("FAIL model t=%0t: got mc=%b sec=%0d chg=%b, want mc=%b sec=%0d chg=%b",
                         $time, MASTER_CONTROL, SECONDS, MODE_CHANGE, 2'(m_mode), m_sec, m_mc);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse_start();
        START_PULSE = 1'b1; cyc(1); START_PULSE = 1'b0;
    endtask

    task automatic pulse_stop();
        STOP_PULSE = 1'b1; cyc(1); STOP_PULSE = 1'b0;
    endtask

    initial begin
        // reset
        cyc(2);
        chk("reset_mc", MASTER_CONTROL, 0);
        chk("reset_sec", SECONDS, 0);
        chk("reset_chg", MODE_CHANGE, 0);
        RESET = 1'b1;

        // full run to PATTERN
        pulse_start();
        chk("start_mc", MASTER_CONTROL, 1);
        chk("start_chg", MODE_CHANGE, 1);
        cyc(1);
        chk("start_chg_drop", MODE_CHANGE, 0);
        cyc(3);
        chk("sec1", SECONDS, 1);
        cyc(4);
        chk("sec2", SECONDS, 2);
        cyc(3);
        chk("pre_pattern_mc", MASTER_CONTROL, 1);
        cyc(1);
        chk("pattern_mc", MASTER_CONTROL, 2);
        chk("pattern_sec", SECONDS, 3);
        chk("pattern_chg", MODE_CHANGE, 1);

        // frames: long tick levels count once each; START ignored in PATTERN
        FRAME_TICK = 1'b1; cyc(5);
        FRAME_TICK = 1'b0;
        chk("one_frame_mc", MASTER_CONTROL, 2);
        pulse_start();
        chk("pattern_start_ignored", MASTER_CONTROL, 2);
        cyc(9);
        FRAME_TICK = 1'b1; cyc(1);
        chk("done_mc", MASTER_CONTROL, 3);
        chk("done_chg", MODE_CHANGE, 1);
        cyc(4);
        FRAME_TICK = 1'b0;
        chk("done_sec_frozen", SECONDS, 3);

        // DONE: start+stop together -> IDLE
        START_PULSE = 1'b1; STOP_PULSE = 1'b1; cyc(1);
        START_PULSE = 1'b0; STOP_PULSE = 1'b0;
        chk("done_both_mc", MASTER_CONTROL, 0);

        // fresh run, full 12 cycles to PATTERN
        pulse_start();
        chk("rerun_sec", SECONDS, 0);
        cyc(11);
        chk("rerun_still_run", MASTER_CONTROL, 1);
        cyc(1);
        chk("rerun_pattern", MASTER_CONTROL, 2);
        pulse_stop();
        chk("pattern_stop_mc", MASTER_CONTROL, 0);
        chk("pattern_stop_sec", SECONDS, 0);

        // STOP coincident with final terminal count
        pulse_start();
        cyc(11);
        chk("pre_stop_sec", SECONDS, 2);
        pulse_stop();
        chk("stop_tc_mc", MASTER_CONTROL, 0);
        chk("stop_tc_sec", SECONDS, 0);
        cyc(3);
        chk("stop_tc_stays_idle", MASTER_CONTROL, 0);

        // START in RUN restarts the timer without a mode change
        pulse_start();
        cyc(5);
        chk("restart_pre_sec", SECONDS, 1);
        pulse_start();
        chk("restart_mc", MASTER_CONTROL, 1);
        chk("restart_sec", SECONDS, 0);
        chk("restart_chg", MODE_CHANGE, 0);

        // reset mid-RUN
        cyc(8);
        chk("midrun_sec", SECONDS, 2);
        RESET = 1'b0; cyc(1); RESET = 1'b1;
        chk("midrst_mc", MASTER_CONTROL, 0);
        chk("midrst_sec", SECONDS, 0);
        chk("midrst_chg", MODE_CHANGE, 0);

        // STOP in IDLE does nothing
        pulse_stop();
        chk("idle_stop_mc", MASTER_CONTROL, 0);
        chk("idle_stop_chg", MODE_CHANGE, 0);
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
